// File: rtl/life_pkg.sv
// Shared types, constants and the board-scrambling LFSR for the life sequencer.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAND  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        HALT  = 3'd4
    } life_state_t;

    localparam logic [63:0] DEFAULT_SEED = 64'h0412_6424_0034_3C28;

    // Taps for x^64+x^63+x^61+x^60+1 on a left-shifting register: bits 63,62,60,59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_next(logic [63:0] cur);
        return {cur[62:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/life_tick_div.sv
// Generation pacing counter: counts 0..TICK_DIV-1 while enabled, tick at terminal count.
module life_tick_div #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

    logic [15:0] cnt;

    assign tick = enable && (cnt == TERM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Board owner for the 8x8 automaton: seeds, scrambles, paces and freezes the board,
// handing the current board to the external evolve datapath and taking its result back.
module life_sequencer
    import life_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 4,
    parameter logic [63:0] DEFAULT_SEED = life_pkg::DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        step,
    input  logic        randomize,
    input  logic        load,
    input  logic [63:0] load_seed,
    input  logic [63:0] board_next,
    output logic [63:0] board,
    output logic [15:0] gen_count,
    output logic        gen_strobe,
    output logic        running,
    output logic        stable,
    output life_state_t state
);

    life_state_t nxt_state;
    logic [63:0] nxt_board;
    logic [15:0] nxt_gen;
    logic        nxt_strobe;
    logic        apply;
    logic        tick;
    logic        tick_clear;

    // The divider only advances in RUN; a pause restarts the phase from zero.
    assign tick_clear = (state != RUN) || pause;

    life_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .enable(state == RUN),
        .tick  (tick)
    );

    always_comb begin
        nxt_state  = state;
        nxt_board  = board;
        nxt_gen    = gen_count;
        nxt_strobe = 1'b0;
        apply      = 1'b0;

        if (randomize) begin
            nxt_state = RAND;
            // An all-zero board would lock the LFSR, so reseed instead.
            nxt_board = (board == '0) ? DEFAULT_SEED : lfsr_next(board);
            nxt_gen   = '0;
        end else if (load) begin
            nxt_state = PAUSE;
            nxt_board = load_seed;
            nxt_gen   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pause && start) nxt_state = RUN;
                end
                RAND: begin
                    nxt_state = PAUSE;
                end
                RUN: begin
                    if (pause)     nxt_state = PAUSE;
                    else if (tick) apply = 1'b1;
                end
                PAUSE: begin
                    if (!pause) begin
                        if (start)     nxt_state = RUN;
                        else if (step) apply = 1'b1;
                    end
                end
                HALT: begin
                    nxt_state = HALT;
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end

        // A generation that changes nothing is a still life: freeze instead of counting it.
        if (apply) begin
            if (board_next != board) begin
                nxt_board  = board_next;
                nxt_gen    = (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
                nxt_strobe = 1'b1;
            end else begin
                nxt_state = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            board      <= DEFAULT_SEED;
            gen_count  <= '0;
            gen_strobe <= 1'b0;
            running    <= 1'b0;
            stable     <= 1'b0;
        end else begin
            state      <= nxt_state;
            board      <= nxt_board;
            gen_count  <= nxt_gen;
            gen_strobe <= nxt_strobe;
            running    <= (nxt_state == RUN);
            stable     <= (nxt_state == HALT);
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a bounded-edge Life model as the evolve datapath.
module tb_life_sequencer;
    import life_pkg::*;

    localparam logic [63:0] SEED0    = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK    = 64'h0000_0018_1800_0000;
    localparam logic [63:0] OTHER    = 64'h00FF_0000_0000_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, pause, step, randomize, load;
    logic [63:0] load_seed;
    logic [63:0] board_next;
    logic [63:0] board;
    logic [15:0] gen_count;
    logic        gen_strobe, running, stable;
    life_state_t state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    life_sequencer #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .step      (step),
        .randomize (randomize),
        .load      (load),
        .load_seed (load_seed),
        .board_next(board_next),
        .board     (board),
        .gen_count (gen_count),
        .gen_strobe(gen_strobe),
        .running   (running),
        .stable    (stable),
        .state     (state)
    );

    function automatic logic [63:0] life_model(input logic [63:0] b);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            if (b[(r + dr) * 8 + (c + dc)]) cnt++;
                        end
                    end
                end
                n[r * 8 + c] = b[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] lfsr_model(input logic [63:0] b);
        return {b[62:0], b[63] ^ b[62] ^ b[60] ^ b[59]};
    endfunction

    assign board_next = life_model(board);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_board_q(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, board, e);
        end
    endtask

    task automatic load_board(input logic [63:0] seed);
        load = 1'b1;
        load_seed = seed;
        step_clk();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {start, pause, step, randomize, load} = '0;
        load_seed = '0;
        repeat (3) step_clk();

        // Reset values
        chk("rst_board", board, SEED0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_strobe", 64'(gen_strobe), 64'd0);
        chk("rst_state", 64'(state), 64'(IDLE));
        #3 reset = 1'b1;
        step_clk();

        // step in IDLE is ignored
        step = 1'b1;
        step_clk();
        step = 1'b0;
        chk("idle_step_board", board, SEED0);
        chk("idle_step_state", 64'(state), 64'(IDLE));

        // Free run with the blinker
        load_board(BLINK_H);
        chk("load_board", board, BLINK_H);
        chk("load_state", 64'(state), 64'(PAUSE));
        exp_q.push_back(life_model(BLINK_H));
        exp_q.push_back(life_model(life_model(BLINK_H)));
        exp_q.push_back(life_model(life_model(life_model(BLINK_H))));
        start = 1'b1;
        step_clk();
        start = 1'b0;
        chk("run_running", 64'(running), 64'd1);
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            chk($sformatf("run_strobe_%0d", k), 64'(gen_strobe), 64'((k % 4) == 0));
            if ((k % 4) == 0) chk_board_q($sformatf("run_board_%0d", k));
        end
        chk("run_gen", 64'(gen_count), 64'd3);
        chk("run_phase", board, BLINK_V);

        // pause coincident with terminal count: no generation
        repeat (3) step_clk();
        pause = 1'b1;
        step_clk();
        pause = 1'b0;
        chk("pause_tc_strobe", 64'(gen_strobe), 64'd0);
        chk("pause_tc_board", board, BLINK_V);
        chk("pause_tc_gen", 64'(gen_count), 64'd3);
        chk("pause_tc_state", 64'(state), 64'(PAUSE));

        // step held two cycles in PAUSE
        load_board(BLINK_H);
        exp_q.push_back(BLINK_V);
        exp_q.push_back(BLINK_H);
        step = 1'b1;
        step_clk();
        chk("step1_strobe", 64'(gen_strobe), 64'd1);
        chk_board_q("step1_board");
        step_clk();
        step = 1'b0;
        chk("step2_strobe", 64'(gen_strobe), 64'd1);
        chk_board_q("step2_board");
        chk("step_gen", 64'(gen_count), 64'd2);
        chk("step_state", 64'(state), 64'(PAUSE));

        // Still life halts at the first tick
        load_board(BLOCK);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        repeat (3) step_clk();
        chk("block_pre_running", 64'(running), 64'd1);
        chk("block_pre_stable", 64'(stable), 64'd0);
        step_clk();
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_strobe", 64'(gen_strobe), 64'd0);
        chk("block_board", board, BLOCK);
        chk("block_gen", 64'(gen_count), 64'd0);
        chk("block_running", 64'(running), 64'd0);
        start = 1'b1;
        step = 1'b1;
        step_clk();
        start = 1'b0;
        step = 1'b0;
        chk("halt_start_state", 64'(state), 64'(HALT));
        chk("halt_start_running", 64'(running), 64'd0);

        // Randomize from an empty board
        load_board(64'd0);
        exp_q.push_back(SEED0);
        exp_q.push_back(lfsr_model(SEED0));
        exp_q.push_back(lfsr_model(lfsr_model(SEED0)));
        randomize = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            chk_board_q($sformatf("rand_board_%0d", k));
            chk($sformatf("rand_state_%0d", k), 64'(state), 64'(RAND));
        end
        randomize = 1'b0;
        e = board;
        step_clk();
        chk("rand_rel_state", 64'(state), 64'(PAUSE));
        chk("rand_rel_board", board, lfsr_model(lfsr_model(SEED0)));
        chk("rand_rel_gen", 64'(gen_count), 64'd0);

        // Priority: randomize > load > start, then load > start
        load_board(BLINK_H);
        exp_q.push_back(lfsr_model(BLINK_H));
        randomize = 1'b1;
        load = 1'b1;
        start = 1'b1;
        load_seed = OTHER;
        step_clk();
        randomize = 1'b0;
        chk("prio_rand_state", 64'(state), 64'(RAND));
        chk_board_q("prio_rand_board");
        step_clk();
        load = 1'b0;
        start = 1'b0;
        chk("prio_load_state", 64'(state), 64'(PAUSE));
        chk("prio_load_board", board, OTHER);
        chk("prio_load_running", 64'(running), 64'd0);

        // Reset in the middle of RUN
        load_board(BLINK_H);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        repeat (5) step_clk();
        chk("pre_rst_gen", 64'(gen_count), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_board", board, SEED0);
        chk("mid_rst_gen", 64'(gen_count), 64'd0);
        chk("mid_rst_running", 64'(running), 64'd0);
        chk("mid_rst_state", 64'(state), 64'(IDLE));
        #2 reset = 1'b1;
        step_clk();
        chk("post_rst_state", 64'(state), 64'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
